// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Field names keep the fetch-side direction suffixes so both ends read the same.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, 2-entry response buffer,
// redirect with stale-response discard, and a stallable decode output register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr_o,
  output logic [31:0]         pc_o,
  output logic                valid_o
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  disc_q, disc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic req, acc, rsp_vld, rsp_take, push, pop;

  // Credit rule: in-flight requests plus buffered entries never exceed two,
  // so every returning response always has a buffer slot.
  assign req      = !rst && !redirect_i && (({1'b0, out_q} + {1'b0, cnt_q}) < 3'd2);
  assign acc      = req && imem.imem_gnt_i;
  assign rsp_vld  = imem.imem_rvalid_i && (out_q != 2'd0);
  assign rsp_take = rsp_vld && (disc_q == 2'd0) && !redirect_i;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = fetch_pc_q;

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + {1'b0, acc} - {1'b0, rsp_vld};
    disc_d     = disc_q;
    push       = 1'b0;
    pop        = 1'b0;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      rsp_pc_d   = redirect_pc_i;
      disc_d     = out_q - {1'b0, rsp_vld};
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
    end else begin
      if (acc) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_vld && (disc_q != 2'd0)) disc_d = disc_q - 2'd1;
      if (rsp_take) rsp_pc_d = rsp_pc_q + 32'd4;

      if (stall_i) begin
        push = rsp_take;
      end else if (cnt_q != 2'd0) begin
        pop     = 1'b1;
        push    = rsp_take;
        valid_d = 1'b1;
        instr_d = fifo_instr_q[rd_ptr_q];
        pc_d    = fifo_pc_q[rd_ptr_q];
      end else if (rsp_take) begin
        valid_d = 1'b1;
        instr_d = imem.imem_rdata_i;
        pc_d    = rsp_pc_q;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end

    cnt_d    = redirect_i ? 2'd0 : (cnt_q + {1'b0, push} - {1'b0, pop});
    wr_ptr_d = redirect_i ? 1'b0 : (wr_ptr_q ^ push);
    rd_ptr_d = redirect_i ? 1'b0 : (rd_ptr_q ^ pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= 2'd0;
      disc_q     <= 2'd0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Buffer payload needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem.imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory with random latency plus a
// program-order reference model of fetch addresses and delivered PCs.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int K_RST = 0, K_RED = 1, K_STALL = 2, K_NORM = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  logic        req_obs, acc_obs;
  logic [31:0] addr_obs;
  logic        o_valid, p_valid;
  logic [31:0] o_instr, o_pc, p_instr, p_pc;
  int          kind;
  logic [31:0] exp_fetch, exp_pc, acc_exp, new_pc;
  logic        new_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5C3_0000) + 32'h0000_1001;
  endfunction

  // One clock of stimulus; memory answers in order once a request's due cycle arrives.
  task automatic cycle(input logic r, input logic st, input logic rd, input logic [31:0] tgt,
                       input logic g, input int lat, input logic spur);
    rst = r; stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
    bus.imem_gnt_i = g; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
    if (spur) begin
      bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    end else if (!r && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end
    #1;
    req_obs = bus.imem_req_o; addr_obs = bus.imem_addr_o; acc_obs = req_obs & g;
    p_valid = valid_o; p_instr = instr_o; p_pc = pc_o;
    acc_exp = exp_fetch; new_ins = 1'b0; new_pc = exp_pc;
    if (acc_obs && !r) begin mq_addr.push_back(addr_obs); mq_due.push_back(cyc + lat); end
    if (r) begin
      kind = K_RST; exp_fetch = RESET_PC; exp_pc = RESET_PC;
      mq_addr.delete(); mq_due.delete();
    end else if (rd) begin
      kind = K_RED; exp_fetch = tgt; exp_pc = tgt;
    end else begin
      if (acc_obs) exp_fetch = exp_fetch + 32'd4;
      kind = st ? K_STALL : K_NORM;
    end
    @(posedge clk); #1; cyc++;
    o_valid = valid_o; o_instr = instr_o; o_pc = pc_o;
    if (kind == K_NORM && o_valid) begin new_ins = 1'b1; new_pc = exp_pc; exp_pc = exp_pc + 32'd4; end
  endtask

  task automatic run(input logic st, input logic g, input int lat);
    cycle(1'b0, st, 1'b0, 32'h0, g, lat, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", o_valid); else pass_cnt++;
    total_cnt++; if (o_instr !== NOP_INSTR) $display("FAIL rst_instr got %h want %h", o_instr, NOP_INSTR); else pass_cnt++;
    total_cnt++; if (o_pc !== RESET_PC) $display("FAIL rst_pc got %h want %h", o_pc, RESET_PC); else pass_cnt++;
    total_cnt++; if (req_obs !== 1'b0) $display("FAIL rst_req got %0b want 0", req_obs); else pass_cnt++;
    run(1'b0, 1'b1, 1);
    total_cnt++; if (req_obs !== 1'b1) $display("FAIL first_req got %0b want 1", req_obs); else pass_cnt++;
    total_cnt++; if (addr_obs !== RESET_PC) $display("FAIL first_addr got %h want %h", addr_obs, RESET_PC); else pass_cnt++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run(1'b0, 1'b1, 1);
      total_cnt++;
      if (acc_obs !== 1'b1 || addr_obs !== 32'(4 * k))
        $display("FAIL stream_addr k=%0d got acc=%0b addr=%h want acc=1 addr=%h", k, acc_obs, addr_obs, 32'(4 * k));
      else pass_cnt++;
      total_cnt++;
      if (k == 0) begin
        if (o_valid !== 1'b0) $display("FAIL stream_fill got valid=%0b want 0", o_valid); else pass_cnt++;
      end else if (o_valid !== 1'b1 || o_pc !== 32'(4 * (k - 1)) || o_instr !== mem_word(32'(4 * (k - 1))))
        $display("FAIL stream_out k=%0d got v=%0b pc=%h i=%h want v=1 pc=%h", k, o_valid, o_pc, o_instr, 32'(4 * (k - 1)));
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) run(1'b0, 1'b1, 1);
    for (int s = 0; s < 3; s++) begin
      run(1'b1, 1'b1, 1);
      total_cnt++;
      if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instr !== mem_word(32'h8))
        $display("FAIL stall_hold s=%0d got v=%0b pc=%h i=%h want v=1 pc=00000008", s, o_valid, o_pc, o_instr);
      else pass_cnt++;
      if (s == 2) begin
        total_cnt++; if (req_obs !== 1'b0) $display("FAIL stall_req got %0b want 0", req_obs); else pass_cnt++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      run(1'b0, 1'b1, 1);
      total_cnt++;
      if (o_valid !== 1'b1 || o_pc !== 32'(12 + 4 * j) || o_instr !== mem_word(32'(12 + 4 * j)))
        $display("FAIL stall_resume j=%0d got v=%0b pc=%h want v=1 pc=%h", j, o_valid, o_pc, 32'(12 + 4 * j));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    int  nv;
    logic first_acc;
    nv = 0; first_acc = 1'b1;
    do_reset();
    run(1'b0, 1'b1, 3);
    run(1'b0, 1'b1, 3);
    cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 3, 1'b0);
    total_cnt++; if (req_obs !== 1'b0) $display("FAIL redir_req got %0b want 0", req_obs); else pass_cnt++;
    total_cnt++;
    if (o_valid !== 1'b0 || o_instr !== NOP_INSTR) $display("FAIL redir_out got v=%0b i=%h want v=0 i=%h", o_valid, o_instr, NOP_INSTR);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      run(1'b0, 1'b1, 3);
      if (acc_obs && first_acc) begin
        first_acc = 1'b0;
        total_cnt++; if (addr_obs !== 32'h100) $display("FAIL redir_addr got %h want 00000100", addr_obs); else pass_cnt++;
      end
      if (o_valid && nv < 2) begin
        total_cnt++;
        if (o_pc !== 32'(32'h100 + 4 * nv) || o_instr !== mem_word(32'(32'h100 + 4 * nv)))
          $display("FAIL redir_seq n=%0d got pc=%h i=%h want pc=%h", nv, o_pc, o_instr, 32'(32'h100 + 4 * nv));
        else pass_cnt++;
        nv++;
      end
    end
    total_cnt++; if (nv != 2) $display("FAIL redir_timeout got %0d want 2", nv); else pass_cnt++;
  endtask

  task automatic test_redirect_stall();
    int nv;
    nv = 0;
    do_reset();
    for (int k = 0; k < 4; k++) run(1'b0, 1'b1, 1);
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b1, 1);
    cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1, 1'b0);
    total_cnt++;
    if (o_valid !== 1'b0 || o_instr !== NOP_INSTR || req_obs !== 1'b0)
      $display("FAIL rs_out got v=%0b i=%h req=%0b want v=0 i=%h req=0", o_valid, o_instr, req_obs, NOP_INSTR);
    else pass_cnt++;
    run(1'b0, 1'b1, 1);
    total_cnt++; if (acc_obs !== 1'b1 || addr_obs !== 32'h200) $display("FAIL rs_addr got %h want 00000200", addr_obs); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (o_valid && nv < 2) begin
        total_cnt++;
        if (o_pc !== 32'(32'h200 + 4 * nv) || o_instr !== mem_word(32'(32'h200 + 4 * nv)))
          $display("FAIL rs_seq n=%0d got pc=%h want pc=%h", nv, o_pc, 32'(32'h200 + 4 * nv));
        else pass_cnt++;
        nv++;
      end
      run(1'b0, 1'b1, 1);
    end
    total_cnt++; if (nv != 2) $display("FAIL rs_timeout got %0d want 2", nv); else pass_cnt++;
  endtask

  task automatic test_gnt_low();
    do_reset();
    for (int k = 0; k < 3; k++) run(1'b0, 1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      run(1'b0, 1'b0, 1);
      total_cnt++;
      if (req_obs !== 1'b1 || addr_obs !== 32'hC) $display("FAIL gnt_hold k=%0d got req=%0b addr=%h want req=1 addr=0000000c", k, req_obs, addr_obs);
      else pass_cnt++;
    end
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL gnt_drain got %0b want 0", o_valid); else pass_cnt++;
    run(1'b0, 1'b1, 1);
    total_cnt++; if (acc_obs !== 1'b1 || addr_obs !== 32'hC) $display("FAIL gnt_resume got %h want 0000000c", addr_obs); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int nv;
    nv = 0;
    do_reset();
    for (int k = 0; k < 4; k++) run(1'b0, 1'b1, 2);
    run(1'b1, 1'b1, 2);
    run(1'b1, 1'b1, 2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 2, 1'b0);
    total_cnt++;
    if (o_valid !== 1'b0 || o_instr !== NOP_INSTR || o_pc !== RESET_PC || req_obs !== 1'b0)
      $display("FAIL midrst_out got v=%0b i=%h pc=%h req=%0b want v=0 i=%h pc=%h req=0", o_valid, o_instr, o_pc, req_obs, NOP_INSTR, RESET_PC);
    else pass_cnt++;
    run(1'b0, 1'b1, 2);
    total_cnt++; if (req_obs !== 1'b1 || addr_obs !== RESET_PC) $display("FAIL midrst_req got req=%0b addr=%h want 1 %h", req_obs, addr_obs, RESET_PC); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      run(1'b0, 1'b1, 2);
      if (o_valid && nv == 0) begin
        total_cnt++;
        if (o_pc !== RESET_PC || o_instr !== mem_word(RESET_PC)) $display("FAIL midrst_first got pc=%h i=%h want pc=%h", o_pc, o_instr, RESET_PC);
        else pass_cnt++;
        nv++;
      end
    end
    total_cnt++; if (nv != 1) $display("FAIL midrst_timeout got %0d want 1", nv); else pass_cnt++;
  endtask

  task automatic test_spurious();
    int nv;
    nv = 0;
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b1);
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL spur_valid got %0b want 0", o_valid); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      run(1'b0, 1'b1, 1);
      if (o_valid && nv == 0) begin
        total_cnt++;
        if (o_pc !== RESET_PC || o_instr !== mem_word(RESET_PC)) $display("FAIL spur_first got pc=%h i=%h want pc=%h", o_pc, o_instr, RESET_PC);
        else pass_cnt++;
        nv++;
      end
    end
    total_cnt++; if (nv != 1) $display("FAIL spur_timeout got %0d want 1", nv); else pass_cnt++;
  endtask

  task automatic test_random();
    int ninstr;
    logic st, rd, g;
    logic [31:0] tgt;
    ninstr = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rd  = ($urandom_range(0, 99) < 4);
      st  = ($urandom_range(0, 99) < 25);
      g   = ($urandom_range(0, 99) < 70);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      cycle(1'b0, st, rd, tgt, g, int'($urandom_range(1, 3)), 1'b0);
      if (rd) begin
        total_cnt++; if (req_obs !== 1'b0) $display("FAIL rnd_redir_req c=%0d got %0b want 0", cyc, req_obs); else pass_cnt++;
      end
      if (acc_obs) begin
        total_cnt++; if (addr_obs !== acc_exp) $display("FAIL rnd_addr c=%0d got %h want %h", cyc, addr_obs, acc_exp); else pass_cnt++;
      end
      total_cnt++;
      if (kind == K_RED) begin
        if (o_valid !== 1'b0 || o_instr !== NOP_INSTR || o_pc !== p_pc)
          $display("FAIL rnd_redir c=%0d got v=%0b i=%h pc=%h want v=0 i=%h pc=%h", cyc, o_valid, o_instr, o_pc, NOP_INSTR, p_pc);
        else pass_cnt++;
      end else if (kind == K_STALL) begin
        if ({o_valid, o_instr, o_pc} !== {p_valid, p_instr, p_pc})
          $display("FAIL rnd_stall c=%0d got v=%0b i=%h pc=%h want v=%0b i=%h pc=%h", cyc, o_valid, o_instr, o_pc, p_valid, p_instr, p_pc);
        else pass_cnt++;
      end else if (new_ins) begin
        ninstr++;
        if (o_pc !== new_pc || o_instr !== mem_word(new_pc))
          $display("FAIL rnd_seq c=%0d got pc=%h i=%h want pc=%h i=%h", cyc, o_pc, o_instr, new_pc, mem_word(new_pc));
        else pass_cnt++;
      end else begin
        if (o_instr !== NOP_INSTR) $display("FAIL rnd_idle c=%0d got i=%h want %h", cyc, o_instr, NOP_INSTR); else pass_cnt++;
      end
    end
    total_cnt++; if (ninstr < 100) $display("FAIL rnd_progress got %0d want >=100", ninstr); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
    exp_fetch = RESET_PC; exp_pc = RESET_PC; kind = K_RST;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_gnt_low();
    test_reset_midop();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
